// File: rtl/input_conditioner.sv
`default_nettype none
// input_conditioner: sync + debounce of five key inputs, one-clk command pulses
// with DAS/ARR auto-repeat on left/right/down. Rev 1.0
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 834600,
  parameter int DAS_DELAY       = 10,
  parameter int ARR             = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_game,
  input  logic       raw_left,
  input  logic       raw_right,
  input  logic       raw_down,
  input  logic       raw_rotate,
  input  logic       raw_drop,
  output logic       cmd_left,
  output logic       cmd_right,
  output logic       cmd_down,
  output logic       cmd_rotate,
  output logic       cmd_drop,
  output logic [4:0] held
);

  localparam int NCH      = 5;
  localparam int NREP     = 3;
  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TICK_MAX = (DAS_DELAY > ARR) ? DAS_DELAY : ARR;
  localparam int TK_W     = $clog2(TICK_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } rep_state_t;

  logic [NCH-1:0]  raw;
  logic [NCH-1:0]  sync1;
  logic [NCH-1:0]  sync2;
  logic [NCH-1:0]  deb;
  logic [NCH-1:0]  deb_d;
  logic [NCH-1:0]  rise;
  logic [DB_W-1:0] db_cnt [NCH];

  rep_state_t      state    [NREP];
  rep_state_t      state_nx [NREP];
  logic [TK_W-1:0] tcnt     [NREP];
  logic [TK_W-1:0] tcnt_nx  [NREP];
  logic [NREP-1:0] press;
  logic [NREP-1:0] kill;
  logic [NCH-1:0]  pulse_nx;
  logic [NCH-1:0]  cmd;

  // Channel order matches held: {drop, rotate, down, right, left}
  assign raw  = {raw_drop, raw_rotate, raw_down, raw_right, raw_left};
  assign rise = deb & ~deb_d;
  assign held = deb;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < NCH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Left wins a simultaneous left/right press; a press of either direction
  // parks the opposite FSM in IDLE, where it stays until a fresh press edge.
  assign press[0] = rise[0];
  assign press[1] = rise[1] & ~rise[0];
  assign press[2] = rise[2];
  assign kill[0]  = press[1];
  assign kill[1]  = rise[0];
  assign kill[2]  = 1'b0;

  always_comb begin
    pulse_nx = '0;
    for (int i = 0; i < NREP; i++) begin
      state_nx[i] = state[i];
      tcnt_nx[i]  = tcnt[i];
      if (kill[i]) begin
        state_nx[i] = S_IDLE;
        tcnt_nx[i]  = '0;
      end else begin
        case (state[i])
          S_IDLE: begin
            if (press[i]) begin
              state_nx[i] = S_DELAY;
              tcnt_nx[i]  = '0;
              pulse_nx[i] = 1'b1;
            end
          end
          S_DELAY: begin
            if (!deb[i]) begin
              state_nx[i] = S_IDLE;
              tcnt_nx[i]  = '0;
            end else if (tick_game) begin
              if (tcnt[i] == TK_W'(DAS_DELAY - 1)) begin
                state_nx[i] = S_REPEAT;
                tcnt_nx[i]  = '0;
                pulse_nx[i] = 1'b1;
              end else begin
                tcnt_nx[i] = tcnt[i] + TK_W'(1);
              end
            end
          end
          S_REPEAT: begin
            if (!deb[i]) begin
              state_nx[i] = S_IDLE;
              tcnt_nx[i]  = '0;
            end else if (tick_game) begin
              if (tcnt[i] == TK_W'(ARR - 1)) begin
                tcnt_nx[i]  = '0;
                pulse_nx[i] = 1'b1;
              end else begin
                tcnt_nx[i] = tcnt[i] + TK_W'(1);
              end
            end
          end
          default: begin
            state_nx[i] = S_IDLE;
            tcnt_nx[i]  = '0;
          end
        endcase
      end
    end
    pulse_nx[3] = rise[3];
    pulse_nx[4] = rise[4];
  end

  // The ~cmd mask guarantees no command is ever high on two adjacent cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd <= '0;
      for (int i = 0; i < NREP; i++) begin
        state[i] <= S_IDLE;
        tcnt[i]  <= '0;
      end
    end else begin
      cmd <= pulse_nx & ~cmd;
      for (int i = 0; i < NREP; i++) begin
        state[i] <= state_nx[i];
        tcnt[i]  <= tcnt_nx[i];
      end
    end
  end

  assign cmd_left   = cmd[0];
  assign cmd_right  = cmd[1];
  assign cmd_down   = cmd[2];
  assign cmd_rotate = cmd[3];
  assign cmd_drop   = cmd[4];

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// tb_input_conditioner: directed checks of debounce, single-shot, DAS/ARR,
// left/right exclusion, reset and press/tick collision.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_game = 1'b0;
  logic       raw_left = 1'b0;
  logic       raw_right = 1'b0;
  logic       raw_down = 1'b0;
  logic       raw_rotate = 1'b0;
  logic       raw_drop = 1'b0;
  logic       cmd_left;
  logic       cmd_right;
  logic       cmd_down;
  logic       cmd_rotate;
  logic       cmd_drop;
  logic [4:0] held;

  int n_checks = 0;
  int n_pass   = 0;
  int n_dbl    = 0;
  int ecnt     = 0;
  int tick_org = 0;
  int q_left[$];
  int q_right[$];
  int q_down[$];
  int q_rot[$];
  int q_drop[$];
  logic [4:0] cmd_prev = '0;

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .DAS_DELAY      (3),
    .ARR            (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_game (tick_game),
    .raw_left  (raw_left),
    .raw_right (raw_right),
    .raw_down  (raw_down),
    .raw_rotate(raw_rotate),
    .raw_drop  (raw_drop),
    .cmd_left  (cmd_left),
    .cmd_right (cmd_right),
    .cmd_down  (cmd_down),
    .cmd_rotate(cmd_rotate),
    .cmd_drop  (cmd_drop),
    .held      (held)
  );

  always #5 clk = ~clk;

  // ecnt numbers posedges; at a negedge it names the edge just taken.
  always @(posedge clk) ecnt <= ecnt + 1;

  // tick_game is high for edge e when e - tick_org is a non-negative multiple of 10.
  always @(negedge clk) begin
    int d;
    d = ecnt + 1 - tick_org;
    tick_game = (d >= 0) && (d % 10 == 0);
  end

  always @(negedge clk) begin
    logic [4:0] cmds;
    cmds = {cmd_drop, cmd_rotate, cmd_down, cmd_right, cmd_left};
    if (cmd_left)   q_left.push_back(ecnt);
    if (cmd_right)  q_right.push_back(ecnt);
    if (cmd_down)   q_down.push_back(ecnt);
    if (cmd_rotate) q_rot.push_back(ecnt);
    if (cmd_drop)   q_drop.push_back(ecnt);
    if ((cmds & cmd_prev) != 5'b0) n_dbl++;
    cmd_prev = cmds;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_pulses(input string tag, input int got[$], input int base,
                              input int exp[$]);
    check({tag, "_count"}, got.size(), exp.size());
    foreach (exp[i]) begin
      check($sformatf("%s_%0d", tag, i), (i < got.size()) ? got[i] - base : -1, exp[i]);
    end
  endtask

  task automatic goto_edge(input int e);
    while (ecnt < e) @(negedge clk);
  endtask

  task automatic clear_q();
    q_left.delete();
    q_right.delete();
    q_down.delete();
    q_rot.delete();
    q_drop.delete();
  endtask

  initial begin
    int e1;
    int exp[$];

    repeat (3) @(negedge clk);
    check("rst_held", int'(held), 0);
    check("rst_cmd", int'({cmd_drop, cmd_rotate, cmd_down, cmd_right, cmd_left}), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Glitch: three sampling edges high are one short of the debounce window.
    clear_q();
    e1 = ecnt + 1;
    raw_left = 1'b1;
    goto_edge(e1 + 2);
    raw_left = 1'b0;
    goto_edge(e1 + 5);
    check("glitch_held", int'(held[0]), 0);
    goto_edge(e1 + 40);
    check("glitch_pulses", q_left.size(), 0);

    // Hold left 200 cycles: press at +6, DAS on 3rd tick, ARR every 2nd tick.
    clear_q();
    e1 = ecnt + 1;
    tick_org = e1;
    raw_left = 1'b1;
    goto_edge(e1 + 100);
    check("hold_held", int'(held), 5'b00001);
    goto_edge(e1 + 199);
    raw_left = 1'b0;
    goto_edge(e1 + 250);
    check("hold_released", int'(held), 0);
    exp = '{6, 30, 50, 70, 90, 110, 130, 150, 170, 190};
    check_pulses("hold_left", q_left, e1, exp);

    // Single-shot rotate and drop.
    clear_q();
    e1 = ecnt + 1;
    raw_rotate = 1'b1;
    goto_edge(e1 + 299);
    raw_rotate = 1'b0;
    goto_edge(e1 + 330);
    exp = '{6};
    check_pulses("rotate", q_rot, e1, exp);
    clear_q();
    e1 = ecnt + 1;
    raw_drop = 1'b1;
    goto_edge(e1 + 19);
    raw_drop = 1'b0;
    goto_edge(e1 + 50);
    check_pulses("drop", q_drop, e1, exp);

    // Exclusion: right pressed while left repeats.
    clear_q();
    e1 = ecnt + 1;
    tick_org = e1;
    raw_left = 1'b1;
    goto_edge(e1 + 74);
    raw_right = 1'b1;
    goto_edge(e1 + 85);
    check("excl_held", int'(held), 5'b00011);
    goto_edge(e1 + 94);
    raw_right = 1'b0;
    goto_edge(e1 + 199);
    raw_left = 1'b0;
    goto_edge(e1 + 240);
    exp = '{6, 30, 50, 70};
    check_pulses("excl_left", q_left, e1, exp);
    exp = '{81};
    check_pulses("excl_right", q_right, e1, exp);

    // Simultaneous left and right press: left only.
    clear_q();
    e1 = ecnt + 1;
    tick_org = e1;
    raw_left = 1'b1;
    raw_right = 1'b1;
    goto_edge(e1 + 99);
    raw_left = 1'b0;
    raw_right = 1'b0;
    goto_edge(e1 + 140);
    exp = '{6, 30, 50, 70, 90};
    check_pulses("simul_left", q_left, e1, exp);
    check("simul_right_count", q_right.size(), 0);

    // Reset while down repeats, then re-press from scratch.
    clear_q();
    e1 = ecnt + 1;
    tick_org = e1;
    raw_down = 1'b1;
    goto_edge(e1 + 54);
    rst = 1'b1;
    goto_edge(e1 + 55);
    rst = 1'b0;
    check("midrst_cmd", int'({cmd_drop, cmd_rotate, cmd_down, cmd_right, cmd_left}), 0);
    check("midrst_held", int'(held), 0);
    goto_edge(e1 + 99);
    raw_down = 1'b0;
    goto_edge(e1 + 140);
    exp = '{6, 30, 50, 62, 90};
    check_pulses("rst_down", q_down, e1, exp);

    // Collision: press edge coincides with a tick, which must not count.
    clear_q();
    e1 = ecnt + 1;
    tick_org = e1 + 6;
    raw_down = 1'b1;
    goto_edge(e1 + 39);
    raw_down = 1'b0;
    goto_edge(e1 + 80);
    exp = '{6, 36};
    check_pulses("coll_down", q_down, e1, exp);
    check("coll_left_count", q_left.size(), 0);

    check("no_back_to_back", n_dbl, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
